// File: rtl/spike_pkg.sv
// Shared types and helpers for the spike decoding blocks: default widths,
// decoder state enum and a saturating increment.
package spike_pkg;

    localparam int SPIKE_CNT_W = 8;
    localparam int SPIKE_ISI_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    // Increment only when asked and only while below the ceiling, so counters never wrap
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value,
                                            input logic        inc);
        if (inc && (value < max_value)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Registers the neuron spike level and emits a one-cycle pulse on its rising edge.
module spike_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic spike,
    output logic spike_rise
);

    logic spike_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike;
        end
    end

    assign spike_rise = spike & ~spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a neuron spike train into a per-window rising-edge count with a
// valid/ready handshake. Optional inter-spike interval output when the macro
// SPIKE_DEC_ISI_EN is defined; otherwise isi/isi_valid are tied to 0.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = SPIKE_CNT_W,
    parameter int ISI_W  = SPIKE_ISI_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    localparam int                WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [31:0]       CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

    dec_state_t       state_q;
    dec_state_t       state_d;
    logic             spike_rise;
    logic             active;
    logic             close;
    logic             accept;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] result;

    spike_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .spike      (spike),
        .spike_rise (spike_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counting starts the cycle after enable is seen, so a level already high is not counted
    assign active = (state_q == RUN) && enable;
    assign close  = active && (win_cnt == WIN_LAST);
    assign accept = rate_valid && rate_ready;
    assign result = CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX, spike_rise));

    always_ff @(posedge clk) begin
        if (reset || !active || close) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            spk_cnt <= result;
        end
    end

    // A closing window wins over a same-cycle accept; overrun only when the old result was refused
    always_ff @(posedge clk) begin
        if (reset) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (close) begin
                rate       <= result;
                rate_valid <= 1'b1;
            end else if (accept) begin
                rate_valid <= 1'b0;
            end
            if (close && rate_valid && !rate_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SPIKE_DEC_ISI_EN
    localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

    logic             armed;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_q;
    logic             isi_valid_q;

    // The counter restarts at 1 on an edge so that its value at the next edge is the distance
    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b0;
            isi_cnt     <= '0;
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
        end else begin
            isi_valid_q <= 1'b0;
            if (!active) begin
                armed   <= 1'b0;
                isi_cnt <= '0;
            end else if (spike_rise) begin
                armed   <= 1'b1;
                isi_cnt <= ISI_W'(1);
                if (armed) begin
                    isi_q       <= isi_cnt;
                    isi_valid_q <= 1'b1;
                end
            end else begin
                isi_cnt <= ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX, 1'b1));
            end
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder at WINDOW=16, with a
// second narrow instance (CNT_W=3, ISI_W=4) for saturation corners.
module tb_spike_rate_decoder;

    localparam int WINDOW = 16;
`ifdef SPIKE_DEC_ISI_EN
    localparam int ISI_BUILD = 1;
`else
    localparam int ISI_BUILD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spike;
    logic        rate_ready;
    logic [7:0]  rate;
    logic        rate_valid;
    logic        overrun;
    logic [15:0] isi;
    logic        isi_valid;
    logic [2:0]  rate_c3;
    logic        rate_valid_c3;
    logic        overrun_c3;
    logic [3:0]  isi_c3;
    logic        isi_valid_c3;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         n_edges;
        logic       rdy;
        logic       rdy_last;
        logic       first_valid;
        logic       first_overrun;
        logic [7:0] exp_rate;
        logic       exp_valid;
        logic       exp_overrun;
    } win_vec_t;

    win_vec_t tab[6];

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(8), .ISI_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike      (spike),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .isi        (isi),
        .isi_valid  (isi_valid)
    );

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(3), .ISI_W(4)) dut_c3 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike      (spike),
        .rate       (rate_c3),
        .rate_valid (rate_valid_c3),
        .rate_ready (rate_ready),
        .overrun    (overrun_c3),
        .isi        (isi_c3),
        .isi_valid  (isi_valid_c3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic sp, input logic rdy);
        enable     = en;
        spike      = sp;
        rate_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic go_idle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tab[0] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0};
        tab[1] = '{5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1};
        tab[2] = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0};
        tab[3] = '{8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8, 1'b1, 1'b0};
        tab[4] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1};
        tab[5] = '{4, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0};

        do_reset();
        checkOutput("reset_rate", rate, 0);
        checkOutput("reset_rate_valid", rate_valid, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_isi", isi, 0);
        checkOutput("reset_isi_valid", isi_valid, 0);

        // Spikes every 4 cycles with an always-ready consumer
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 48; c++) begin
            applyStimulus(1'b1, (c % 4) == 0, 1'b1);
            tick();
            if ((c % WINDOW) == WINDOW - 1) begin
                checkOutput("every4_rate", rate, 4);
                checkOutput("every4_valid", rate_valid, 1);
                checkOutput("every4_overrun", overrun, 0);
            end else begin
                checkOutput("every4_valid_pulse", rate_valid, 0);
            end
            if ((c % 4) == 0) begin
                checkOutput("every4_isi_valid", isi_valid, (c >= 4) ? ISI_BUILD : 0);
                checkOutput("every4_isi", isi, (c >= 4) ? 4 * ISI_BUILD : 0);
            end
        end
        go_idle();

        // Level held high from the enable cycle never produces an edge
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 39; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            tick();
            checkOutput("held_isi_valid", isi_valid, 0);
            if ((c % WINDOW) == WINDOW - 1) begin
                checkOutput("held_rate", rate, 0);
                checkOutput("held_valid", rate_valid, 1);
            end
        end
        go_idle();

        // Eight edges in one window saturate a 3-bit count
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < WINDOW; c++) begin
            applyStimulus(1'b1, (c % 2) == 0, 1'b1);
            tick();
        end
        checkOutput("sat_rate_c3", rate_c3, 7);
        checkOutput("sat_valid_c3", rate_valid_c3, 1);
        checkOutput("sat_rate_wide", rate, 8);
        go_idle();

        // Window-level handshake table: overrun, accept, close-with-accept
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < WINDOW; c++) begin
                applyStimulus(1'b1, ((c % 2) == 1) && ((c / 2) < tab[r].n_edges),
                              (c == WINDOW - 1) ? tab[r].rdy_last : tab[r].rdy);
                tick();
                if (c == 0) begin
                    checkOutput($sformatf("tab%0d_first_valid", r), rate_valid, tab[r].first_valid);
                    checkOutput($sformatf("tab%0d_first_overrun", r), overrun, tab[r].first_overrun);
                end
                if (c == WINDOW - 1) begin
                    checkOutput($sformatf("tab%0d_rate", r), rate, tab[r].exp_rate);
                    checkOutput($sformatf("tab%0d_valid", r), rate_valid, tab[r].exp_valid);
                    checkOutput($sformatf("tab%0d_overrun", r), overrun, tab[r].exp_overrun);
                end
            end
        end
        go_idle();

        // Edge in the closing cycle, then an empty window, then reset mid-window
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < WINDOW; c++) begin
                applyStimulus(1'b1, (w != 1) && (c == WINDOW - 1), 1'b1);
                tick();
                if (w == 1 && c == 0) checkOutput("close_edge_accepted", rate_valid, 0);
            end
            checkOutput($sformatf("close_edge_w%0d_rate", w), rate, (w == 1) ? 0 : 1);
            checkOutput($sformatf("close_edge_w%0d_valid", w), rate_valid, 1);
        end
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(1'b1, c == 2, 1'b0);
            reset = (c == 8);
            tick();
        end
        reset = 1'b0;
        checkOutput("midreset_rate", rate, 0);
        checkOutput("midreset_valid", rate_valid, 0);
        checkOutput("midreset_overrun", overrun, 0);
        checkOutput("midreset_isi", isi, 0);
        checkOutput("midreset_isi_valid", isi_valid, 0);
        for (int c = 0; c < 15; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            tick();
            checkOutput("after_reset_no_result", rate_valid, 0);
        end
        go_idle();

        // Inter-spike intervals from edges at cycles 3, 10 and 30
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 32; c++) begin
            applyStimulus(1'b1, (c == 3) || (c == 10) || (c == 30), 1'b1);
            tick();
            if (c == 3) checkOutput("isi_first_edge_arms", isi_valid, 0);
            if (c == 10) begin
                checkOutput("isi_7_valid", isi_valid, ISI_BUILD);
                checkOutput("isi_7", isi, 7 * ISI_BUILD);
                checkOutput("isi_7_c3", isi_c3, 7 * ISI_BUILD);
            end
            if (c == 11) begin
                checkOutput("isi_valid_one_cycle", isi_valid, 0);
                checkOutput("isi_7_hold", isi, 7 * ISI_BUILD);
            end
            if (c == 30) begin
                checkOutput("isi_20_valid", isi_valid, ISI_BUILD);
                checkOutput("isi_20", isi, 20 * ISI_BUILD);
                checkOutput("isi_sat_c3", isi_c3, 15 * ISI_BUILD);
            end
        end
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Consumes the 1-bit `spike` output of a neuron (LIF/MTF) and converts it to numeric activity for downstream motor/servo logic. It reports a spike count per fixed window through a valid/ready handshake and, optionally, the inter-spike interval (ISI). It sits between the neuron array and the gait/servo controllers and is the reading end of the neuron's spike interface.

## Interface
Parameters:
- `WINDOW`, 256: window length in clk cycles (≥2).
- `CNT_W`, 8: width of `rate`; count saturates at 2^CNT_W−1.
- `ISI_W`, 16: width of `isi`; interval saturates at 2^ISI_W−1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  1 = decode; 0 = idle, counters cleared.
- `spike`  in  1  neuron spike level, synchronous to `clk`.
- `rate`  out  CNT_W  rising edges counted in the last completed window.
- `rate_valid`  out  1  `rate` holds an unconsumed result.
- `rate_ready`  in  1  consumer accepts when `rate_valid && rate_ready`.
- `overrun`  out  1  sticky; a completed window overwrote an unconsumed result.
- `isi`  out  ISI_W  cycles between the last two rising edges (ISI build only).
- `isi_valid`  out  1  one-cycle pulse on a new `isi` (ISI build only).

## Operation
- Edge detect: `edge = spike & ~spike_q`, where `spike_q` is registered `spike`. Only rising edges count; a held-high `spike` counts once.
- States: IDLE (`enable`=0) and RUN (`enable`=1).
  - IDLE→RUN when `enable` rises. Window counter and spike counter start at 0, and `spike_q` is kept, so a level already high is not counted.
  - RUN→IDLE when `enable` falls. The partial window is discarded without output. `rate`/`rate_valid`/`overrun` hold their values.
- Window: `win_cnt` counts 0..WINDOW−1 in RUN.
  - In the cycle `win_cnt`==WINDOW−1, the result is `spk_cnt + edge` (saturating). The result is loaded into `rate`; `win_cnt` and `spk_cnt` clear.
  - An edge in the closing cycle belongs to the closing window.
- `spk_cnt` saturates at 2^CNT_W−1 and never wraps.
- Handshake:
  - `rate_valid` sets on window close.
  - `rate_valid` clears on `rate_valid && rate_ready`, unless a window closes in the same cycle. In that case `rate_valid` stays 1, `rate` takes the new value, and `overrun` is not set.
  - If a window closes while `rate_valid`=1 and `rate_ready`=0, `rate` is overwritten and `overrun` is set.
  - `overrun` clears only on an accepted transfer (`rate_valid && rate_ready`) when it is not re-set in the same cycle.
  - `rate` is stable while `rate_valid`=1, except on an overwrite.
- Reset: the entire block is cleared (see Timing).

## Timing
- Reset values: `rate`=0, `rate_valid`=0, `overrun`=0, `isi`=0, `isi_valid`=0. `spike_q`, counters, and ISI state are 0, with no previous edge.
- Rate latency: `rate`/`rate_valid` are valid the cycle after the closing cycle. The first result appears WINDOW cycles after the first RUN cycle.
- ISI latency: `isi`/`isi_valid` are registered the cycle after the second edge.
- Reset asserted mid-window or mid-handshake clears everything on the next edge. No result is emitted.

## Configuration
- Macro `SPIKE_DEC_ISI_EN`.
- Defined:
  - An ISI counter runs in RUN, incrementing each cycle and saturating.
  - On an edge with a previous edge recorded, `isi` gets the edge-to-edge distance: edges at cycles t1 and t2 give t2−t1, saturated.
  - `isi_valid` pulses for 1 cycle, and the counter restarts.
  - The first edge after reset or `enable` rise only arms the counter.
  - IDLE clears the armed flag and the counter.
- Undefined: no ISI logic. `isi` and `isi_valid` ports remain and are tied to 0.

## Structure
- Shared package `spike_pkg`:
  - default widths `SPIKE_CNT_W`=8 and `SPIKE_ISI_W`=16;
  - state enum `dec_state_t` {IDLE, RUN};
  - a saturating-increment function.
- One sub-module, `spike_edge_detect`: registered level, rising-edge pulse output, synchronous reset.

## Test plan
- Use WINDOW=16 for all scenarios.
- 1-cycle spikes every 4 cycles, `rate_ready`=1 → `rate`=4 each window, `rate_valid` for 1 cycle every 16 cycles, `overrun`=0.
- `spike` held high for 40 cycles from the enable cycle → `rate`=0 in every window; no ISI.
- CNT_W=3, spike every other cycle → `rate`=7 (saturated), not 0.
- `rate_ready`=0 across two windows (counts 3 then 5) → `rate`=5 and `overrun`=1. One accept with `rate_ready`=1 → `rate_valid`=0 and `overrun`=0.
- Edge in cycle 15 of a window → counted in that window (`rate`=1); next window `rate`=0. Reset at cycle 8 → no output, all outputs 0.
- ISI build, edges at cycles 3, 10, 30 → `isi`=7, then `isi`=20, each with a 1-cycle `isi_valid`. ISI_W=4 with a 20-cycle gap → `isi`=15.
